// File: rtl/imm_pkg.sv
// Shared immediate-format definitions for the packer and the decoder's sign-extension path.
package imm_pkg;

    localparam int INSTR_W = 38;
    localparam int IMM_W   = 24;

    typedef enum logic [1:0] {
        IMM_10   = 2'b00,
        IMM_16   = 2'b01,
        IMM_2    = 2'b10,
        IMM_NONE = 2'b11
    } imm_src_t;

    function automatic int unsigned field_width(input imm_src_t src);
        case (src)
            IMM_10:  return 10;
            IMM_16:  return 16;
            IMM_2:   return 2;
            default: return 0;
        endcase
    endfunction

    // Low-order ones covering the immediate field; zero for IMM_NONE.
    function automatic logic [IMM_W-1:0] field_mask(input imm_src_t src);
        logic [IMM_W:0] one_hot;
        one_hot = (IMM_W+1)'(1) << field_width(src);
        return IMM_W'(one_hot - (IMM_W+1)'(1));
    endfunction

endpackage

// File: rtl/imm_fit_check.sv
// Combinational range check and field truncation of an immediate for one format.
module imm_fit_check
    import imm_pkg::*;
(
    input  logic [IMM_W-1:0] imm,
    input  imm_src_t         src,
    output logic             fits,
    output logic [IMM_W-1:0] field
);

    // The value fits when every bit from the field's sign bit upward is identical.
    always_comb begin
        fits = 1'b1;
        case (src)
            IMM_10:  fits = (&imm[IMM_W-1:9])  | ~(|imm[IMM_W-1:9]);
            IMM_16:  fits = (&imm[IMM_W-1:15]) | ~(|imm[IMM_W-1:15]);
            IMM_2:   fits = (&imm[IMM_W-1:1])  | ~(|imm[IMM_W-1:1]);
            default: fits = 1'b1;
        endcase
    end

    assign field = imm & field_mask(src);

endmodule

// File: rtl/imm_packer.sv
// Two-stage valid/ready pipeline inserting a range-checked immediate into an instruction word.
module imm_packer
    import imm_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int ERR_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [IMM_W-1:0]   in_imm,
    input  logic [1:0]         in_imm_src,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               out_range_err,
    output logic [ERR_W-1:0]   err_count
);

    logic               s1_valid;
    logic [INSTR_W-1:0] s1_instr;
    logic [IMM_W-1:0]   s1_imm;
    imm_src_t           s1_src;

    logic               s2_valid;
    logic [INSTR_W-1:0] s2_instr;
    logic               s2_err;

    logic [ADDR_W-1:0]  addr_cnt;
    logic [ERR_W-1:0]   err_cnt;

    logic               s1_fits;
    logic [IMM_W-1:0]   s1_field;
    logic [INSTR_W-1:0] merged;
    logic               merged_err;
    logic               s1_load;
    logic               s2_load;
    logic               out_hs;

    imm_fit_check u_fit (
        .imm   (s1_imm),
        .src   (s1_src),
        .fits  (s1_fits),
        .field (s1_field)
    );

    assign merged     = (s1_instr & ~INSTR_W'(field_mask(s1_src))) | INSTR_W'(s1_field);
    assign merged_err = (s1_src != IMM_NONE) & ~s1_fits;

    assign s2_load  = ~s2_valid | out_ready;
    assign s1_load  = ~s1_valid | s2_load;
    assign in_ready = s1_load;
    assign out_hs   = s2_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_instr <= '0;
            s1_imm   <= '0;
            s1_src   <= IMM_NONE;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_instr <= in_instr;
                s1_imm   <= in_imm;
                s1_src   <= imm_src_t'(in_imm_src);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_instr <= '0;
            s2_err   <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_instr <= merged;
                s2_err   <= merged_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt <= '0;
            err_cnt  <= '0;
        end else if (out_hs) begin
            addr_cnt <= addr_cnt + 1'b1;
            if (s2_err && err_cnt != {ERR_W{1'b1}})
                err_cnt <= err_cnt + 1'b1;
        end
    end

    assign out_valid     = s2_valid;
    assign out_instr     = s2_instr;
    assign out_range_err = s2_err;
    assign out_addr      = addr_cnt;
    assign err_count     = err_cnt;

endmodule

// File: tb/tb_imm_packer.sv
// Scoreboard bench for imm_packer: default-sized and narrow-counter instances share one stimulus stream.
module tb_imm_packer;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [37:0] in_instr;
    logic [23:0] in_imm;
    logic [1:0]  in_imm_src;
    logic        out_ready;

    logic        in_ready, out_valid, out_range_err;
    logic [37:0] out_instr;
    logic [9:0]  out_addr;
    logic [15:0] err_count;

    logic        in_ready_s, out_valid_s, out_range_err_s;
    logic [37:0] out_instr_s;
    logic [1:0]  out_addr_s;
    logic [1:0]  err_count_s;

    always #5 clk = ~clk;

    imm_packer #(.ADDR_W(10), .ERR_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_imm(in_imm), .in_imm_src(in_imm_src),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_range_err(out_range_err), .err_count(err_count)
    );

    imm_packer #(.ADDR_W(2), .ERR_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_instr(in_instr), .in_imm(in_imm), .in_imm_src(in_imm_src),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_instr(out_instr_s),
        .out_addr(out_addr_s), .out_range_err(out_range_err_s), .err_count(err_count_s)
    );

    typedef struct {
        logic [37:0] instr;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   vec = 0;
    int   errs = 0;
    int   mode = 0;
    int   exp_addr = 0, exp_addr_s = 0, exp_err = 0, exp_err_s = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: the field holds imm modulo 2^N; it fits iff the signed value is in [-2^(N-1), 2^(N-1)).
    function automatic exp_t model(input logic [37:0] instr, input logic [23:0] imm, input logic [1:0] src);
        exp_t   e;
        int     n;
        longint v, lim, msk;
        n = (src == 2'd0) ? 10 : (src == 2'd1) ? 16 : (src == 2'd2) ? 2 : 0;
        if (n == 0) begin
            e.instr = instr;
            e.err   = 1'b0;
        end else begin
            v       = longint'($signed(imm));
            lim     = longint'(1) << (n - 1);
            msk     = (longint'(1) << n) - 1;
            e.err   = !(v >= -lim && v < lim);
            e.instr = (instr & ~38'(msk)) | (38'(imm) & 38'(msk));
        end
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    logic        held = 1'b0;
    logic [37:0] held_instr;
    logic [9:0]  held_addr;
    logic        held_err;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held && out_valid) begin
                chk("stall_instr", 64'(out_instr), 64'(held_instr));
                chk("stall_addr", 64'(out_addr), 64'(held_addr));
                chk("stall_err", 64'(out_range_err), 64'(held_err));
            end
            chk("err_count", 64'(err_count), 64'(exp_err));
            chk("err_count_s", 64'(err_count_s), 64'(exp_err_s));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 64'(1), 64'(0));
                end else begin
                    e = q.pop_front();
                    chk("instr", 64'(out_instr), 64'(e.instr));
                    chk("range_err", 64'(out_range_err), 64'(e.err));
                    chk("addr", 64'(out_addr), 64'(exp_addr));
                    chk("valid_s", 64'(out_valid_s), 64'(1));
                    chk("instr_s", 64'(out_instr_s), 64'(e.instr));
                    chk("addr_s", 64'(out_addr_s), 64'(exp_addr_s));
                    exp_addr   = (exp_addr + 1) % 1024;
                    exp_addr_s = (exp_addr_s + 1) % 4;
                    if (e.err) begin
                        if (exp_err < 65535) exp_err++;
                        if (exp_err_s < 3) exp_err_s++;
                    end
                end
                held = 1'b0;
            end else if (out_valid) begin
                held       = 1'b1;
                held_instr = out_instr;
                held_addr  = out_addr;
                held_err   = out_range_err;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic send(input logic [37:0] instr, input logic [23:0] imm, input logic [1:0] src);
        int   guard;
        logic acc;
        guard      = 0;
        in_valid   = 1'b1;
        in_instr   = instr;
        in_imm     = imm;
        in_imm_src = src;
        do begin
            @(negedge clk);
            acc = in_ready;
            if (acc) q.push_back(model(instr, imm, src));
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        if (!acc) chk("accept_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("drain_timeout", 64'(q.size()), 64'(0));
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic rand_word();
        logic [23:0] imm;
        case ($urandom_range(0, 3))
            0:       imm = 24'($urandom);
            1:       imm = 24'($signed(10'($urandom)));
            2:       imm = 24'($signed(2'($urandom)));
            default: imm = 24'($signed(16'($urandom)));
        endcase
        send({6'($urandom), 32'($urandom)}, imm, 2'($urandom_range(0, 3)));
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_instr   = '0;
        in_imm     = '0;
        in_imm_src = '0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_instr", 64'(out_instr), 64'(0));
        chk("rst_out_addr", 64'(out_addr), 64'(0));
        chk("rst_range_err", 64'(out_range_err), 64'(0));
        chk("rst_err_count", 64'(err_count), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        send(38'h3F_FFFF_FC00, 24'hFFFFFE, 2'b00);
        @(negedge clk);
        chk("latency_t1", 64'(out_valid), 64'(0));
        @(negedge clk);
        chk("latency_t2", 64'(out_valid), 64'(1));
        chk("first_instr", 64'(out_instr), 64'(38'h3F_FFFF_FFFE));
        @(posedge clk);
        #1;

        send(38'h12_3456_7890, 24'h000200, 2'b00);
        send(38'h12_3456_7890, 24'h0001FF, 2'b00);
        send(38'h00_0000_0000, 24'hFFFFFF, 2'b10);
        send(38'h00_0000_0000, 24'h000002, 2'b10);
        send(38'h2A_BCDE_F012, 24'h123456, 2'b11);
        send(38'h15_5555_5555, 24'hFF8000, 2'b01);
        send(38'h15_5555_5555, 24'h008000, 2'b01);
        drain();

        mode = 1;
        repeat (8) rand_word();
        drain();

        mode = 2;
        repeat (300) begin
            rand_word();
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        mode = 0;
        drain();

        mode = 3;
        @(posedge clk);
        #1;
        send(38'h01_0000_0001, 24'h000200, 2'b00);
        send(38'h02_0000_0002, 24'h000200, 2'b00);
        rst = 1'b1;
        q.delete();
        exp_addr = 0; exp_addr_s = 0; exp_err = 0; exp_err_s = 0;
        @(posedge clk);
        #1;
        chk("midrst_valid", 64'(out_valid), 64'(0));
        chk("midrst_addr", 64'(out_addr), 64'(0));
        chk("midrst_err_count", 64'(err_count), 64'(0));
        chk("midrst_err_count_s", 64'(err_count_s), 64'(0));
        rst  = 1'b0;
        mode = 0;
        send(38'h3F_0000_0000, 24'h000005, 2'b00);
        repeat (6) rand_word();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/imm_packer.md
# imm_packer

Inverse of the immediate sign-extension path: takes a 38-bit instruction word, a 24-bit immediate and an immediate-format select, then inserts the immediate into that format's field. It range-checks the value so that the decoder's sign extension reproduces it exactly. It is a 2-stage valid/ready pipeline between the program loader and instruction memory, and produces a sequential write address for each emitted word.

## Interface
- ADDR_W, 10, width of the instruction-memory write address counter
- ERR_W, 16, width of the saturating range-error counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word present
- in_ready  out  1  block can accept input this cycle
- in_instr  in  38  base instruction; immediate field contents ignored
- in_imm  in  24  two's-complement immediate value
- in_imm_src  in  2  format select: 00 = 10-bit field [9:0], 01 = 16-bit [15:0], 10 = 2-bit [1:0], 11 = no immediate
- out_valid  out  1  packed word present
- out_ready  in  1  consumer accepts this cycle
- out_instr  out  38  instruction with immediate inserted
- out_addr  out  ADDR_W  write address paired with out_instr
- out_range_err  out  1  immediate did not fit the selected field
- err_count  out  ERR_W  number of emitted words with out_range_err = 1, saturating

## Operation
- Field width N: 10, 16 or 2 for imm_src 00, 01 or 10. For these formats, bits [N-1:0] of out_instr = in_imm[N-1:0]. Bits [37:N] pass through from in_instr unchanged.
- For imm_src 11, out_instr = in_instr unchanged and out_range_err = 0.
- Fit rule: in_imm fits only if in_imm[23:N-1] are all equal (all 0s or all 1s). If it does not fit, the truncated field is still written and out_range_err = 1.
- Round-trip requirement: when out_range_err = 0 and imm_src ≠ 11, sign-extending out_instr with the same format returns exactly in_imm.
- Stage 1 registers the inputs, computes the fit result and merges the field. Stage 2 is the output register.
- out_addr is taken from an internal counter. The counter increments by 1 on each output handshake (out_valid & out_ready) and wraps from 2^ADDR_W−1 to 0.
- err_count increments on each output handshake where out_range_err = 1. It holds at 2^ERR_W−1 once reached.

## Timing
- Reset values: out_valid 0, out_instr 0, out_addr 0, out_range_err 0, err_count 0, both stage-valid flags 0. in_ready is 1 in the cycle after reset deasserts.
- Reset mid-operation: both in-flight words are discarded and no handshake is reported for them. The address counter and err_count return to 0.
- Input handshake: in_valid & in_ready. Output handshake: out_valid & out_ready.
- Latency: a word accepted in cycle t appears with out_valid = 1 in cycle t+2 if the pipeline is not stalled.
- Throughput: 1 word per cycle while out_ready = 1.
- Stage 2 loads when it is empty or out_ready = 1. Stage 1 loads when it is empty or stage 2 loads.
- in_ready = !s1_valid | s2_load. It is combinational from out_ready, and there is no combinational path from in_valid.
- While out_valid = 1 and out_ready = 0: out_instr, out_addr and out_range_err hold stable, and the pipeline holds at most 2 words.
- Simultaneous input and output handshakes in the same cycle are legal; no word is lost or duplicated.

## Structure
- Shared package (imm_pkg), shared with the sign-extension logic, contains:
  - typedef imm_src_t with values IMM_10, IMM_16, IMM_2, IMM_NONE
  - constants INSTR_W = 38 and IMM_W = 24
  - a function returning the field width for an imm_src_t
- One sub-module, imm_fit_check: combinational; inputs imm and src, outputs fits and the masked field. It is instantiated in stage 1.
- Pipeline registers, the address counter and the error counter live in the top level.

## Test plan
- Reset, then accept in_instr = 38'h3F_FFFF_FC00, in_imm = 24'hFFFFFE (−2), imm_src 00 with out_ready = 1 → two cycles later out_instr = 38'h3F_FFFF_FFFE, out_range_err 0, out_addr 0.
- in_imm = 24'h000200 (+512), imm_src 00 → out_range_err 1, field [9:0] = 10'h200, err_count 1. Then 24'h0001FF → out_range_err 0.
- imm_src 10 with in_imm 24'hFFFFFF, then 24'h000002 → the first fits with field 2'b11; the second gives out_range_err 1 with field 2'b10. imm_src 11 → out_instr = in_instr.
- Back-to-back stream of 8 words with out_ready toggling every other cycle → outputs arrive in order, out_addr 0..7, nothing lost or duplicated, and outputs stay stable while stalled.
- With ADDR_W = 2, stream 5 words → out_addr sequence 0,1,2,3,0. With ERR_W = 2, 5 range errors → err_count saturates at 3.
- Assert rst while 2 words are in flight → out_valid 0 the next cycle, out_addr and err_count 0, and the words are never emitted.
